// File: rtl/sqrt_pkg.sv
// Shared widths and FSM state encoding for the sequential integer square-root unit.
package sqrt_pkg;
    localparam int RADICAND_W = 64;
    localparam int ROOT_W     = 32;
    localparam int REM_W      = 34;
    localparam int RESULT_W   = 128;
    localparam int CNT_W      = 6;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;
endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root iteration: consumes two radicand bits, resolves one root bit.
module sqrt_step
    import sqrt_pkg::*;
(
    input  logic [REM_W-1:0]  i_rem,
    input  logic [ROOT_W-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [REM_W-1:0]  o_rem,
    output logic [ROOT_W-1:0] o_root
);
    logic [REM_W-1:0] w_rem_sh;
    logic [REM_W-1:0] w_trial;
    logic             w_ge;

    // The remainder never exceeds 2*root, so dropping its top two bits on the shift loses nothing.
    assign w_rem_sh = {i_rem[REM_W-3:0], i_bits};
    assign w_trial  = {i_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign o_root   = {i_root[ROOT_W-2:0], w_ge};
endmodule

// File: rtl/sqrt_calculator.sv
// Self-triggering floor(sqrt(num)) unit; recomputes whenever num differs from the last captured operand.
module sqrt_calculator
    import sqrt_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RADICAND_W-1:0] num,
    output logic [RESULT_W-1:0]   sqrt,
    output logic                  done
);
    localparam int N_ITER = ROOT_W / BITS_PER_CYCLE;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RADICAND_W-1:0] r_op;
    logic                  r_have_op;
    logic [RADICAND_W-1:0] r_rad;
    logic [REM_W-1:0]      r_rem;
    logic [ROOT_W-1:0]     r_root;
    logic [CNT_W-1:0]      r_cnt;
    logic [RESULT_W-1:0]   r_sqrt;
    logic                  r_done;

    logic                  w_capture;
    logic                  w_last;

    logic [BITS_PER_CYCLE:0][REM_W-1:0]  w_rem;
    logic [BITS_PER_CYCLE:0][ROOT_W-1:0] w_root;

    assign w_rem[0]  = r_rem;
    assign w_root[0] = r_root;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        sqrt_step u_step (
            .i_rem  (w_rem[g]),
            .i_root (w_root[g]),
            .i_bits (r_rad[RADICAND_W-1-2*g -: 2]),
            .o_rem  (w_rem[g+1]),
            .o_root (w_root[g+1])
        );
    end

    assign w_capture = !r_have_op || (num != r_op);
    assign w_last    = (r_cnt == CNT_W'(N_ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_state_nxt = CALC;
            CALC:    if (w_last)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_have_op <= 1'b0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_sqrt    <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_op      <= num;
                        r_have_op <= 1'b1;
                        r_done    <= 1'b0;
                        r_rad     <= num;
                        r_rem     <= '0;
                        r_root    <= '0;
                        r_cnt     <= '0;
                    end
                end
                CALC: begin
                    r_rem  <= w_rem[BITS_PER_CYCLE];
                    r_root <= w_root[BITS_PER_CYCLE];
                    r_rad  <= r_rad << (2 * BITS_PER_CYCLE);
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sqrt <= {{(RESULT_W-ROOT_W){1'b0}}, w_root[BITS_PER_CYCLE]};
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sqrt = r_sqrt;
    assign done = r_done;
endmodule

// File: tb/tb_sqrt_calculator.sv
// Scoreboarded bench for sqrt_calculator: directed operands push expected roots, a monitor checks each completion.
module tb_sqrt_calculator;
    localparam int BPC = 8;
    localparam int LAT = 32 / BPC + 1;

    typedef struct {
        logic [63:0] n;
        logic [31:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  num = '0;
    logic [127:0] sqrt;
    logic         done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    sqrt_calculator #(.BITS_PER_CYCLE(BPC)) dut (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .sqrt (sqrt),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of done is one delivered result.
    always @(negedge clk) begin
        if (rst) prev_done = 1'b0;
        else begin
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got %h expected none", sqrt);
                end else begin
                    exp_t e;
                    logic [127:0] r, r1;
                    e = sb.pop_front();
                    check($sformatf("result(%h)", e.n), sqrt, {96'b0, e.r});
                    r  = {96'b0, sqrt[31:0]};
                    r1 = r + 1;
                    checks++;
                    if (!((r * r <= {64'b0, e.n}) && ({64'b0, e.n} < r1 * r1)) || sqrt[127:32] != 0) begin
                        errors++;
                        $display("FAIL floor_prop(%h): got %h expected floor root", e.n, sqrt);
                    end
                end
            end
            prev_done = done;
        end
    end

    function automatic logic [31:0] ref_isqrt(input logic [63:0] n);
        logic [127:0] lo, hi, mid;
        lo = 0; hi = 128'h1_0000_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= {64'b0, n}) lo = mid; else hi = mid;
        end
        return lo[31:0];
    endfunction

    task automatic issue(input logic [63:0] v, input logic [31:0] r);
        exp_t e;
        @(posedge clk); #1;
        num = v;
        e.n = v; e.r = r;
        sb.push_back(e);
    endtask

    // Counts sampled cycles from the capture edge until done is seen; checks sqrt holds meanwhile.
    task automatic wait_done(input string name, input logic [127:0] prev);
        int  cnt = 0;
        logic held = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            cnt++;
            if (done !== 1'b1 && sqrt !== prev) held = 1'b0;
        end while (done !== 1'b1 && cnt < 100);
        check({name, "_latency"}, 128'(cnt), 128'(LAT));
        check({name, "_hold"}, {127'b0, held}, 128'd1);
    endtask

    task automatic hold_stable(input string name, input logic [127:0] v);
        logic ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b1 || sqrt !== v) ok = 1'b0;
        end
        check({name, "_stable"}, {127'b0, ok}, 128'd1);
    endtask

    task automatic run(input string name, input logic [63:0] v, input logic [31:0] r);
        logic [127:0] prev;
        prev = sqrt;
        issue(v, r);
        wait_done(name, prev);
        hold_stable(name, {96'b0, r});
    endtask

    initial begin
        logic [63:0] rv;
        exp_t e;

        repeat (2) @(posedge clk);
        #1;
        check("reset_sqrt", sqrt, 128'd0);
        check("reset_done", {127'b0, done}, 128'd0);
        e.n = 64'd0; e.r = 32'd0;
        sb.push_back(e);
        rst = 1'b0;
        wait_done("first_zero", 128'd0);
        hold_stable("first_zero", 128'd0);

        run("n64",   64'd64,   32'd8);
        run("n1280", 64'd1280, 32'd35);
        run("n4096", 64'd4096, 32'd64);
        run("n8192", 64'd8192, 32'd90);
        run("n1",    64'd1,    32'd1);
        run("n0",    64'd0,    32'd0);
        run("max",   64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        run("sq_max", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        run("sq_max_m1", 64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFE);
        run("n4096b", 64'd4096, 32'd64);

        // Operand changes two edges into CALC: old result first, one-cycle done pulse, then new result.
        issue(64'd64, 32'd8);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        num = 64'd1280;
        e.n = 64'd1280; e.r = 32'd35;
        sb.push_back(e);
        begin
            int cnt = 0;
            while (done !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
            check("midchg_first", sqrt, 128'd8);
            @(negedge clk);
            check("midchg_pulse", {127'b0, done}, 128'd0);
            cnt = 1;
            while (done !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
            check("midchg_gap", 128'(cnt), 128'(LAT));
            check("midchg_second", sqrt, 128'd35);
        end

        // Asynchronous reset mid-computation aborts it.
        issue(64'd8192, 32'd90);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_sqrt", sqrt, 128'd0);
        check("async_rst_done", {127'b0, done}, 128'd0);
        sb.delete();
        e.n = 64'd8192; e.r = 32'd90;
        sb.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("after_rst", 128'd0);

        for (int i = 0; i < 8; i++) begin
            rv = {$urandom(), $urandom()};
            if (i == 0) rv = rv >> 40;
            run($sformatf("rand%0d", i), rv, ref_isqrt(rv));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sqrt_calculator.md
Name: sqrt_calculator

Overview:
Sequential unsigned integer square-root unit: computes floor(sqrt(num)) of a 64-bit operand with a digit-by-digit restoring algorithm, several result bits per clock.
Self-triggering; there is no start strobe. A new computation begins whenever the input operand differs from the last one captured.
The 128-bit result bus carries the 32-bit root zero-extended.
Used as a free-running arithmetic helper fed from a register.

Parameters:
BITS_PER_CYCLE, 8, root bits resolved per clock; legal values 1, 2, 4, 8, 16, 32. Compute latency is 32/BITS_PER_CYCLE cycles.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
num  input  64  unsigned radicand; sampled only at capture.
sqrt  output  128  result register: [31:0] = floor(sqrt(captured num)), [127:32] = 0.
done  output  1  level; high when sqrt holds the result for the most recently captured operand and nothing is pending.

Behaviour:
- Single clock; reset is asynchronous and active-high (rst); all flops clear immediately on rst=1.
- Reset values:
  - sqrt=0, done=0.
  - State IDLE; internal capture register op=0; flag have_op=0.
- States: IDLE, CALC.
- IDLE:
  - If have_op=0 or num != op: capture on this edge.
    - op<=num, have_op<=1, done<=0.
    - Clear remainder/root working regs; load the radicand shift reg with num; iteration counter <= 0.
    - Go to CALC.
  - Otherwise hold; done, sqrt unchanged.
- CALC, each edge: perform BITS_PER_CYCLE restoring steps, unrolled combinationally. One step:
  - rem = (rem<<2) | next two radicand MSBs.
  - trial = (root<<2) | 1.
  - If rem >= trial: rem -= trial, root = (root<<1)|1; else root = root<<1.
- Widths:
  - rem is 34 bits; root is 32 bits.
  - No overflow is possible for any 64-bit input.
- After 32/BITS_PER_CYCLE CALC edges, on the final edge:
  - sqrt <= {96'b0, root}, done <= 1.
  - Go to IDLE.
- Latency:
  - Capture edge plus N=32/BITS_PER_CYCLE compute edges.
  - Default: done rises on the 4th edge after the capture edge, i.e. 5 edges after num is first sampled changed.
- sqrt holds its previous value throughout CALC; it updates only on completion.
- num changing during CALC:
  - Ignored; the computation finishes on the captured op.
  - The next IDLE edge sees num != op and recaptures.
  - done is high for exactly that one IDLE cycle before being cleared.
- num stable: no recomputation; done stays high indefinitely.
- First edge after reset release: captures unconditionally, including num=0, which yields sqrt=0 and done=1.
- rst asserted mid-CALC: abort; return to reset values; the result is not produced.
- Boundary results:
  - num=0 gives 0.
  - num=1 gives 1.
  - num=2^64-1 gives 0xFFFFFFFF.
  - Perfect squares give an exact root; otherwise the floor.

Decomposition:
- Package sqrt_pkg:
  - RADICAND_W=64, ROOT_W=32, REM_W=34, RESULT_W=128.
  - State enum {IDLE, CALC}.
- Sub-module sqrt_step: purely combinational single restoring iteration (rem_in, root_in, two radicand bits -> rem_out, root_out).
  - Instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Reset for 2 cycles with num=0, release -> done=1 and sqrt=0 within 5 cycles; no X on outputs during or after reset.
- num=64, hold >=6 cycles -> done low for 4 cycles, then sqrt=8, done=1, stays stable.
- Sequence 1280 -> 35; 4096 -> 64; 8192 -> 90, each held >=6 cycles.
  - Before each result: done deasserts on the capture edge; sqrt retains the prior value until completion.
- num=0xFFFFFFFFFFFFFFFF -> sqrt=0x00000000FFFFFFFF; also num=0xFFFFFFFE00000001 -> 0xFFFFFFFF and num=0xFFFFFFFE00000000 -> 0xFFFFFFFE.
- Change num 64 -> 1280 two cycles into CALC:
  - 8 is delivered first (done=1 for one cycle).
  - Then 35 after a further 5 cycles.
- Assert rst mid-CALC -> sqrt=0, done=0 immediately (asynchronous); after release the current num is recomputed correctly.
- Random 64-bit operands vs reference: r*r <= num < (r+1)*(r+1) for every result.
- Sweep BITS_PER_CYCLE over 1, 2, 4, 8, 16, 32 -> latency equals 32/BITS_PER_CYCLE.
